control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that replaces hand-stepped bench sequencing of the datapath.
- Runs fetch (T0-T2) and then an opcode-specific execute sequence (T3-T7), driving every datapath control strobe.
- Sits beside the datapath. Takes IR and CON_out from it and returns one-hot enables/selects plus Run.

Parameters:
- ALU_ADD, 3'd0, ALU_op code for add/address/branch-target calc
- ALU_SUB, 3'd1, ALU_op code for sub
- ALU_AND, 3'd2, ALU_op code for and/andi
- ALU_OR, 3'd3, ALU_op code for or/ori

Ports:
- Clock  in  1  system clock, rising edge
- Clear  in  1  synchronous active-high reset
- IR  in  32  instruction register; opcode = IR[31:27]
- CON_out  in  1  branch condition flip-flop output
- Stop  in  1  request halt at next instruction boundary
- PCout, MDRout, ZLowout, Cout, BAout, InPortout, R_out  out  1 each  bus drive selects
- MAR_enable, MDR_enable, IR_enable, Y_enable, ZLowIn, PC_enable, CON_enable, OutPort_enable, R_in  out  1 each  register loads
- Gra, Grb, Grc  out  1 each  register-field selects
- IncPC, MDR_read, RAM_write  out  1 each  PC increment / MDR mux / memory write
- ALU_op  out  3  ALU function
- Run  out  1  high while executing
- State  out  4  current step (debug)

Behaviour:
- Clock is a single clock. Clear is synchronous and active-high, and overrides everything including HALT.
- On Clear the state goes to RESET. Every output is 0, ALU_op=ALU_ADD, Run=0, State=0.
- Transitions: RESET->T0 unconditionally. Run=1 in T0..T7.
- Outputs are a pure decode of state and IR[31:27], so they are valid for the whole step. The datapath captures on the rising edge that ends the step.
- Any strobe not listed for a step is 0. ALU_op=ALU_ADD unless listed.
- Step encodings: RESET 0, T0 1 ... T7 8, HALT 9.
- Fetch:
  - T0: PCout, MAR_enable, IncPC, ZLowIn
  - T1: ZLowout, PC_enable, MDR_read, MDR_enable
  - T2: MDRout, IR_enable
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, jr 10011, in 10110, out 10111, nop 11010, halt 11011. Any other opcode executes as nop.
- R-type add/sub/and/or:
  - T3: Grb R_out Y_enable
  - T4: Grc R_out ZLowIn ALU_op=op
  - T5: ZLowout Gra R_in, then end
- Immediate addi/andi/ori:
  - T3: Grb R_out Y_enable
  - T4: Cout ZLowIn ALU_op=op
  - T5: ZLowout Gra R_in, then end
- ldi:
  - T3: Grb BAout Y_enable
  - T4: Cout ZLowIn
  - T5: ZLowout Gra R_in, then end
- ld:
  - T3-T4: as ldi
  - T5: ZLowout MAR_enable
  - T6: MDR_read MDR_enable
  - T7: MDRout Gra R_in, then end
- st:
  - T3-T5: as ld
  - T6: Gra R_out MDR_enable (MDR_read=0)
  - T7: MDRout RAM_write, then end
- br:
  - T3: Gra R_out CON_enable
  - T4: PCout Y_enable
  - T5: Cout ZLowIn
  - T6: ZLowout, with PC_enable=CON_out sampled in T6; then end
- jr:
  - T3: Gra R_out PC_enable, then end
- in:
  - T3: InPortout Gra R_in, then end
- out:
  - T3: Gra R_out OutPort_enable, then end
- nop:
  - T3: no strobes, then end
- halt:
  - T3: no strobes, then HALT
- End of instruction: next state is T0, or HALT if Stop=1 on that edge.
- Stop has no effect mid-instruction.
- HALT holds with all outputs 0 and Run=0 until Clear.
- Clear asserted mid-instruction aborts the instruction. The next state is RESET and no further strobes are issued; a partially executed st never asserts RAM_write.
- IR is assumed stable from T3 on. The decode uses the live IR.

Test Plan:
- Clear high 2 cycles, then low -> all outputs 0 during RESET; T0 next cycle with PCout=MAR_enable=IncPC=ZLowIn=1, Run=1.
- IR=0x68880005 (andi, opcode 01101) -> T3 Grb R_out Y_enable; T4 Cout ZLowIn ALU_op=2; T5 ZLowout Gra R_in; T0 follows.
- IR opcode st (00010) -> RAM_write high only in T7 with MDRout; MDR_read=0 in T6; 8 steps T0-T7, then T0.
- br with CON_out=0 vs 1 -> PC_enable in T6 is 0 vs 1; all other T3-T6 strobes identical.
- halt opcode -> HALT after T3, Run=0, outputs stay 0 for 10 cycles; Clear -> RESET then T0.
- Stop=1 during add T4 -> add completes T5, then HALT; Clear during ld T6 -> RESET next cycle, no MDRout/R_in.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: three fetch steps followed by an opcode-specific
// execute sequence. Every datapath strobe is decoded from the current step and the live IR opcode.
module control_sequencer #(
    parameter logic [2:0] ALU_ADD = 3'd0,
    parameter logic [2:0] ALU_SUB = 3'd1,
    parameter logic [2:0] ALU_AND = 3'd2,
    parameter logic [2:0] ALU_OR  = 3'd3
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON_out,
    input  logic        Stop,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowout,
    output logic        Cout,
    output logic        BAout,
    output logic        InPortout,
    output logic        R_out,
    output logic        MAR_enable,
    output logic        MDR_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        ZLowIn,
    output logic        PC_enable,
    output logic        CON_enable,
    output logic        OutPort_enable,
    output logic        R_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        MDR_read,
    output logic        RAM_write,
    output logic [2:0]  ALU_op,
    output logic        Run,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
    } state_t;

    state_t state_q, state_d;
    logic   last;

    logic [4:0] opcode;
    logic       unused_ir;
    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    logic op_rtype, op_imm, op_ldi, op_ld, op_st, op_br, op_jr, op_in, op_out, op_halt;
    logic [2:0] alu_sel;

    assign op_rtype = (opcode == 5'b00011) || (opcode == 5'b00100) ||
                      (opcode == 5'b00101) || (opcode == 5'b00110);
    assign op_imm   = (opcode == 5'b01100) || (opcode == 5'b01101) || (opcode == 5'b01110);
    assign op_ldi   = (opcode == 5'b00001);
    assign op_ld    = (opcode == 5'b00000);
    assign op_st    = (opcode == 5'b00010);
    assign op_br    = (opcode == 5'b10010);
    assign op_jr    = (opcode == 5'b10011);
    assign op_in    = (opcode == 5'b10110);
    assign op_out   = (opcode == 5'b10111);
    assign op_halt  = (opcode == 5'b11011);

    always_comb begin
        case (opcode)
            5'b00100:           alu_sel = ALU_SUB;
            5'b00101, 5'b01101: alu_sel = ALU_AND;
            5'b00110, 5'b01110: alu_sel = ALU_OR;
            default:            alu_sel = ALU_ADD;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        PCout = 1'b0;       MDRout = 1'b0;     ZLowout = 1'b0;     Cout = 1'b0;
        BAout = 1'b0;       InPortout = 1'b0;  R_out = 1'b0;       MAR_enable = 1'b0;
        MDR_enable = 1'b0;  IR_enable = 1'b0;  Y_enable = 1'b0;    ZLowIn = 1'b0;
        PC_enable = 1'b0;   CON_enable = 1'b0; OutPort_enable = 1'b0; R_in = 1'b0;
        Gra = 1'b0;         Grb = 1'b0;        Grc = 1'b0;         IncPC = 1'b0;
        MDR_read = 1'b0;    RAM_write = 1'b0;  ALU_op = ALU_ADD;
        last = 1'b0;
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                ZLowout = 1'b1; PC_enable = 1'b1; MDR_read = 1'b1; MDR_enable = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IR_enable = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                if (op_rtype || op_imm) begin
                    Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
                end else if (op_ldi || op_ld || op_st) begin
                    Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
                end else if (op_br) begin
                    Gra = 1'b1; R_out = 1'b1; CON_enable = 1'b1;
                end else if (op_jr) begin
                    Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; last = 1'b1;
                end else if (op_in) begin
                    InPortout = 1'b1; Gra = 1'b1; R_in = 1'b1; last = 1'b1;
                end else if (op_out) begin
                    Gra = 1'b1; R_out = 1'b1; OutPort_enable = 1'b1; last = 1'b1;
                end else if (op_halt) begin
                    state_d = S_HALT;
                end else begin
                    last = 1'b1;
                end
            end
            S_T4: begin
                state_d = S_T5;
                if (op_rtype) begin
                    Grc = 1'b1; R_out = 1'b1; ZLowIn = 1'b1; ALU_op = alu_sel;
                end else if (op_imm) begin
                    Cout = 1'b1; ZLowIn = 1'b1; ALU_op = alu_sel;
                end else if (op_ldi || op_ld || op_st) begin
                    Cout = 1'b1; ZLowIn = 1'b1;
                end else if (op_br) begin
                    PCout = 1'b1; Y_enable = 1'b1;
                end else begin
                    last = 1'b1;
                end
            end
            S_T5: begin
                state_d = S_T6;
                if (op_rtype || op_imm || op_ldi) begin
                    ZLowout = 1'b1; Gra = 1'b1; R_in = 1'b1; last = 1'b1;
                end else if (op_ld || op_st) begin
                    ZLowout = 1'b1; MAR_enable = 1'b1;
                end else if (op_br) begin
                    Cout = 1'b1; ZLowIn = 1'b1;
                end else begin
                    last = 1'b1;
                end
            end
            S_T6: begin
                state_d = S_T7;
                if (op_ld) begin
                    MDR_read = 1'b1; MDR_enable = 1'b1;
                end else if (op_st) begin
                    Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1;
                end else if (op_br) begin
                    // Branch commits only if the condition flop says so
                    ZLowout = 1'b1; PC_enable = CON_out; last = 1'b1;
                end else begin
                    last = 1'b1;
                end
            end
            S_T7: begin
                last = 1'b1;
                if (op_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; R_in = 1'b1;
                end else if (op_st) begin
                    MDRout = 1'b1; RAM_write = 1'b1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
        if (last) state_d = Stop ? S_HALT : S_T0;
    end

    assign Run   = (state_q >= S_T0) && (state_q <= S_T7);
    assign State = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a microprogram-table model predicts every
// output each cycle, and hand-computed literals pin key steps of each scenario.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        Clear, CON_out, Stop;
    logic [31:0] IR;
    logic PCout, MDRout, ZLowout, Cout, BAout, InPortout, R_out, MAR_enable, MDR_enable;
    logic IR_enable, Y_enable, ZLowIn, PC_enable, CON_enable, OutPort_enable, R_in;
    logic Gra, Grb, Grc, IncPC, MDR_read, RAM_write, Run;
    logic [2:0] ALU_op;
    logic [3:0] State;

    control_sequencer dut (
        .Clock(clk), .Clear(Clear), .IR(IR), .CON_out(CON_out), .Stop(Stop),
        .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .Cout(Cout), .BAout(BAout),
        .InPortout(InPortout), .R_out(R_out), .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
        .IR_enable(IR_enable), .Y_enable(Y_enable), .ZLowIn(ZLowIn), .PC_enable(PC_enable),
        .CON_enable(CON_enable), .OutPort_enable(OutPort_enable), .R_in(R_in),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .MDR_read(MDR_read),
        .RAM_write(RAM_write), .ALU_op(ALU_op), .Run(Run), .State(State)
    );

    always #5 clk = ~clk;

    localparam logic [21:0] PCO = 22'h1, MDRO = 22'h2, ZLO = 22'h4, CO = 22'h8;
    localparam logic [21:0] BAO = 22'h10, INO = 22'h20, RO = 22'h40, MARE = 22'h80;
    localparam logic [21:0] MDRE = 22'h100, IRE = 22'h200, YE = 22'h400, ZLI = 22'h800;
    localparam logic [21:0] PCE = 22'h1000, CONE = 22'h2000, OUTE = 22'h4000, RIN = 22'h8000;
    localparam logic [21:0] GRA = 22'h10000, GRB = 22'h20000, GRC = 22'h40000, INC = 22'h80000;
    localparam logic [21:0] MRD = 22'h100000, RAMW = 22'h200000;

    logic [21:0] dut_vec;
    assign dut_vec = {RAM_write, MDR_read, IncPC, Grc, Grb, Gra, R_in, OutPort_enable,
                      CON_enable, PC_enable, ZLowIn, Y_enable, IR_enable, MDR_enable,
                      MAR_enable, R_out, InPortout, BAout, Cout, ZLowout, MDRout, PCout};

    typedef enum int {C_RTYPE, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR, C_IN, C_OUT, C_NOP, C_HALT} cls_t;

    int errors = 0;
    int checks = 0;
    int m_step = 0;   // 0 RESET, 1..8 T0..T7, 9 HALT

    function automatic cls_t classify(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_RTYPE;
            5'b01100, 5'b01101, 5'b01110:           return C_IMM;
            5'b00001: return C_LDI;
            5'b00000: return C_LD;
            5'b00010: return C_ST;
            5'b10010: return C_BR;
            5'b10011: return C_JR;
            5'b10110: return C_IN;
            5'b10111: return C_OUT;
            5'b11011: return C_HALT;
            default:  return C_NOP;
        endcase
    endfunction

    function automatic int exec_len(input cls_t c);
        case (c)
            C_RTYPE, C_IMM, C_LDI: return 3;
            C_LD, C_ST:            return 5;
            C_BR:                  return 4;
            default:               return 1;
        endcase
    endfunction

    // Execute microprogram: k is the execute step index (0 = T3)
    function automatic logic [21:0] exec_strobes(input cls_t c, input int k, input logic con);
        logic [21:0] t3_5 [3];
        logic [21:0] mem5 [5];
        logic [21:0] br4 [4];
        case (c)
            C_RTYPE: begin t3_5 = '{GRB|RO|YE, GRC|RO|ZLI, ZLO|GRA|RIN}; return t3_5[k]; end
            C_IMM:   begin t3_5 = '{GRB|RO|YE, CO|ZLI, ZLO|GRA|RIN};     return t3_5[k]; end
            C_LDI:   begin t3_5 = '{GRB|BAO|YE, CO|ZLI, ZLO|GRA|RIN};    return t3_5[k]; end
            C_LD:    begin mem5 = '{GRB|BAO|YE, CO|ZLI, ZLO|MARE, MRD|MDRE, MDRO|GRA|RIN}; return mem5[k]; end
            C_ST:    begin mem5 = '{GRB|BAO|YE, CO|ZLI, ZLO|MARE, GRA|RO|MDRE, MDRO|RAMW}; return mem5[k]; end
            C_BR:    begin br4 = '{GRA|RO|CONE, PCO|YE, CO|ZLI, con ? (ZLO|PCE) : ZLO}; return br4[k]; end
            C_JR:    return GRA|RO|PCE;
            C_IN:    return INO|GRA|RIN;
            C_OUT:   return GRA|RO|OUTE;
            default: return 22'h0;
        endcase
    endfunction

    function automatic logic [21:0] model_strobes(input int step, input logic [4:0] op, input logic con);
        case (step)
            1: return PCO|MARE|INC|ZLI;
            2: return ZLO|PCE|MRD|MDRE;
            3: return MDRO|IRE;
            4, 5, 6, 7, 8: return exec_strobes(classify(op), step - 4, con);
            default: return 22'h0;
        endcase
    endfunction

    function automatic logic [2:0] model_alu(input int step, input logic [4:0] op);
        cls_t c = classify(op);
        if (step != 5 || !(c == C_RTYPE || c == C_IMM)) return 3'd0;
        case (op)
            5'b00100:           return 3'd1;
            5'b00101, 5'b01101: return 3'd2;
            5'b00110, 5'b01110: return 3'd3;
            default:            return 3'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (model step %0d, IR %08h)", name, got, exp, m_step, IR);
        end
    endtask

    task automatic model_advance();
        cls_t c = classify(IR[31:27]);
        if (Clear) m_step = 0;
        else if (m_step == 0) m_step = 1;
        else if (m_step == 9) m_step = 9;
        else if (m_step <= 3) m_step++;
        else if (m_step - 4 == exec_len(c) - 1) m_step = (c == C_HALT || Stop) ? 9 : 1;
        else m_step++;
    endtask

    // One clock: advance the model on the edge, then compare every output just after it.
    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
        chk("strobes", 32'(dut_vec), 32'(model_strobes(m_step, IR[31:27], CON_out)));
        chk("alu_op", 32'(ALU_op), 32'(model_alu(m_step, IR[31:27])));
        chk("run", 32'(Run), 32'((m_step >= 1 && m_step <= 8) ? 1 : 0));
        chk("state", 32'(State), 32'(m_step));
        $display("cycle: state=%0d run=%0b strobes=%06h alu=%0d IR=%08h", State, Run, dut_vec, ALU_op, IR);
    endtask

    task automatic run_instr(input logic [4:0] op);
        bit done = 0;
        IR = {op, 27'(($urandom))};
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            if (m_step == 1 || m_step == 9) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL instr_end: opcode %05b did not return to T0 within 12 cycles", op);
        end
    endtask

    initial begin
        logic [4:0] ops [12];
        ops = '{5'b00001, 5'b00100, 5'b00110, 5'b01100, 5'b01110, 5'b10011,
                5'b10110, 5'b10111, 5'b11010, 5'b11111, 5'b00101, 5'b00000};
        Clear = 1'b1; Stop = 1'b0; CON_out = 1'b0; IR = 32'h0;

        repeat (2) tick();
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_run", 32'(Run), 32'd0);
        chk("reset_strobes", 32'(dut_vec), 32'd0);

        Clear = 1'b0; IR = 32'h68880005;
        tick();
        chk("t0_state", 32'(State), 32'd1);
        chk("t0_fetch", 32'({PCout, MAR_enable, IncPC, ZLowIn, Run}), 32'b11111);
        repeat (3) tick();
        chk("andi_t3", 32'({Grb, R_out, Y_enable, Cout}), 32'b1110);
        tick();
        chk("andi_t4_alu", 32'(ALU_op), 32'd2);
        chk("andi_t4", 32'({Cout, ZLowIn, R_out}), 32'b110);
        tick();
        chk("andi_t5", 32'({ZLowout, Gra, R_in}), 32'b111);
        tick();
        chk("andi_next", 32'(State), 32'd1);

        IR = 32'h10000000;
        repeat (6) tick();
        chk("st_t6", 32'({MDR_read, MDR_enable, Gra, R_out, RAM_write}), 32'b01110);
        tick();
        chk("st_t7", 32'({MDRout, RAM_write, State}), 32'h38);
        tick();
        chk("st_next", 32'(State), 32'd1);

        IR = 32'h90000000; CON_out = 1'b0;
        repeat (6) tick();
        chk("br_con0_pce", 32'({ZLowout, PC_enable}), 32'b10);
        tick();
        CON_out = 1'b1;
        repeat (6) tick();
        chk("br_con1_pce", 32'({ZLowout, PC_enable}), 32'b11);
        tick();
        CON_out = 1'b0;

        IR = 32'h18000000;
        repeat (4) tick();
        Stop = 1'b1;
        tick();
        chk("stop_mid", 32'({State, Gra, R_in}), 32'h1B);
        tick();
        chk("stop_halt", 32'({State, Run}), 32'h12);
        repeat (2) tick();
        Stop = 1'b0;
        Clear = 1'b1;
        tick();
        chk("halt_clear", 32'(State), 32'd0);

        Clear = 1'b0; IR = 32'h00000000;
        tick();
        repeat (6) tick();
        chk("ld_t6", 32'({State, MDR_read, MDR_enable}), 32'h1F);
        Clear = 1'b1;
        tick();
        chk("ld_abort", 32'({State, MDRout, R_in}), 32'h0);
        Clear = 1'b0;
        tick();

        IR = 32'hD8000000;
        repeat (3) tick();
        chk("halt_t3", 32'({State, dut_vec}), {6'h0, 4'd4, 22'h0});
        tick();
        chk("halt_enter", 32'(State), 32'd9);
        repeat (10) tick();
        chk("halt_hold", 32'({Run, dut_vec}), 32'h0);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        tick();
        chk("halt_restart", 32'(State), 32'd1);

        foreach (ops[i]) run_instr(ops[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
